// File: rtl/motor_drive_stage.sv
// Purpose: turns motor commands into H-bridge direction lines plus two PWM enables from one shared counter.
// Latency: 1 clk from accept to pins; a fwd<->back reversal inserts DEADTIME brake clks first.
// Backpressure: cmd_ready is low in reset, on the first clk after reset, and for the whole brake.
module motor_drive_stage #(
  parameter int unsigned PERIOD    = 1666667,
  parameter int unsigned CNT_W     = 23,
  parameter int unsigned DEADTIME  = 100000,
  parameter int unsigned RAMP_STEP = 66667
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_dir,
  input  logic [CNT_W-1:0] cmd_duty_l,
  input  logic [CNT_W-1:0] cmd_duty_r,
  output logic             cmd_ready,
  output logic             RMF,
  output logic             RMB,
  output logic             LMF,
  output logic             LMB,
  output logic             RM_pwm,
  output logic             LM_pwm,
  output logic             braking
);

  typedef enum logic [1:0] {M_STOP = 2'd0, M_FWD = 2'd1, M_BACK = 2'd2} mdir_t;
  typedef enum logic {S_RUN = 1'b0, S_BRAKE = 1'b1} state_t;

  // Per-motor state: applied direction, latched target duty, duty currently driven.
  typedef struct packed {
    mdir_t            dir;
    logic [CNT_W-1:0] tgt;
    logic [CNT_W-1:0] act;
  } side_t;

  localparam logic [CNT_W-1:0] PER      = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] STEP     = CNT_W'(RAMP_STEP);
  localparam int               BRK_W    = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [BRK_W-1:0] BRK_LOAD = BRK_W'(DEADTIME - 1);

  localparam side_t SIDE_RST = '{dir: M_STOP, tgt: '0, act: '0};

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [BRK_W-1:0] brk_q, brk_nxt;
  side_t            r_q, r_nxt, l_q, l_nxt;
  mdir_t            pend_r_q, pend_r_nxt, pend_l_q, pend_l_nxt;
  mdir_t            new_r, new_l;
  logic             wrap, accept, run_nxt;
  logic             rmf_nxt, rmb_nxt, lmf_nxt, lmb_nxt;
  logic             rpwm_nxt, lpwm_nxt;

  assign wrap = (cnt_q == PER);

  // Command code to right-motor direction; undefined codes mean stop.
  function automatic mdir_t dec_r(input logic [2:0] d);
    case (d)
      3'd0, 3'd1: dec_r = M_FWD;
      3'd2, 3'd4: dec_r = M_BACK;
      default:    dec_r = M_STOP;
    endcase
  endfunction

  // Command code to left-motor direction; undefined codes mean stop.
  function automatic mdir_t dec_l(input logic [2:0] d);
    case (d)
      3'd0, 3'd2: dec_l = M_FWD;
      3'd1, 3'd4: dec_l = M_BACK;
      default:    dec_l = M_STOP;
    endcase
  endfunction

  function automatic logic is_rev(input mdir_t cur, input mdir_t nxt);
    is_rev = ((cur == M_FWD) && (nxt == M_BACK)) || ((cur == M_BACK) && (nxt == M_FWD));
  endfunction

  function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] d);
    clamp = (d > PER) ? PER : d;
  endfunction

  // Increases are limited to STEP per period; decreases land immediately.
  function automatic logic [CNT_W-1:0] ramp(input logic [CNT_W-1:0] act,
                                            input logic [CNT_W-1:0] tgt);
    logic [CNT_W-1:0] diff;
    diff = tgt - act;
    if (tgt > act) ramp = act + ((diff > STEP) ? STEP : diff);
    else           ramp = tgt;
  endfunction

  // Next-state: counter, RUN/BRAKE sequencing, duty ramp and registered-output values.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = wrap ? '0 : cnt_q + CNT_W'(1);
    brk_nxt    = brk_q;
    r_nxt      = r_q;
    l_nxt      = l_q;
    pend_r_nxt = pend_r_q;
    pend_l_nxt = pend_l_q;
    new_r      = dec_r(cmd_dir);
    new_l      = dec_l(cmd_dir);
    accept     = cmd_valid && cmd_ready && (state_q == S_RUN);

    case (state_q)
      S_RUN: begin
        // Ramp only at the wrap so a period never sees two duty values.
        if (wrap) begin
          r_nxt.act = ramp(r_q.act, r_q.tgt);
          l_nxt.act = ramp(l_q.act, l_q.tgt);
        end
        if (accept) begin
          r_nxt.tgt = clamp(cmd_duty_r);
          l_nxt.tgt = clamp(cmd_duty_l);
          if (is_rev(r_q.dir, new_r) || is_rev(l_q.dir, new_l)) begin
            state_nxt  = S_BRAKE;
            brk_nxt    = BRK_LOAD;
            pend_r_nxt = new_r;
            pend_l_nxt = new_l;
          end else begin
            // A motor that changes direction restarts its soft-start from zero.
            if (new_r != r_q.dir) begin
              r_nxt.dir = new_r;
              r_nxt.act = '0;
            end
            if (new_l != l_q.dir) begin
              l_nxt.dir = new_l;
              l_nxt.act = '0;
            end
          end
        end
      end
      S_BRAKE: begin
        if (brk_q == '0) begin
          state_nxt = S_RUN;
          r_nxt.dir = pend_r_q;
          l_nxt.dir = pend_l_q;
          r_nxt.act = '0;
          l_nxt.act = '0;
        end else begin
          brk_nxt = brk_q - BRK_W'(1);
        end
      end
      default: state_nxt = S_RUN;
    endcase

    run_nxt  = (state_nxt == S_RUN);
    rmf_nxt  = run_nxt && (r_nxt.dir == M_FWD);
    rmb_nxt  = run_nxt && (r_nxt.dir == M_BACK);
    lmf_nxt  = run_nxt && (l_nxt.dir == M_FWD);
    lmb_nxt  = run_nxt && (l_nxt.dir == M_BACK);
    rpwm_nxt = run_nxt && (r_nxt.dir != M_STOP) && (cnt_nxt < r_nxt.act);
    lpwm_nxt = run_nxt && (l_nxt.dir != M_STOP) && (cnt_nxt < l_nxt.act);
  end

  // State and output registers; reset overrides everything, including a brake in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      cnt_q     <= '0;
      brk_q     <= '0;
      r_q       <= SIDE_RST;
      l_q       <= SIDE_RST;
      pend_r_q  <= M_STOP;
      pend_l_q  <= M_STOP;
      cmd_ready <= 1'b0;
      RMF       <= 1'b0;
      RMB       <= 1'b0;
      LMF       <= 1'b0;
      LMB       <= 1'b0;
      RM_pwm    <= 1'b0;
      LM_pwm    <= 1'b0;
      braking   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      brk_q     <= brk_nxt;
      r_q       <= r_nxt;
      l_q       <= l_nxt;
      pend_r_q  <= pend_r_nxt;
      pend_l_q  <= pend_l_nxt;
      cmd_ready <= run_nxt;
      RMF       <= rmf_nxt;
      RMB       <= rmb_nxt;
      LMF       <= lmf_nxt;
      LMB       <= lmb_nxt;
      RM_pwm    <= rpwm_nxt;
      LM_pwm    <= lpwm_nxt;
      braking   <= (state_nxt == S_BRAKE);
    end
  end

endmodule

// File: tb/tb_motor_drive_stage.sv
// Directed bench for motor_drive_stage with a small counter model and an expectation queue.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_motor_drive_stage;
  localparam int PERIOD    = 99;
  localparam int CNT_W     = 23;
  localparam int DEADTIME  = 10;
  localparam int RAMP_STEP = 25;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [2:0]       cmd_dir = 3'd3;
  logic [CNT_W-1:0] cmd_duty_l = '0;
  logic [CNT_W-1:0] cmd_duty_r = '0;
  logic             cmd_ready, RMF, RMB, LMF, LMB, RM_pwm, LM_pwm, braking;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   m_cnt = 0;
  int   fb_viol = 0;
  int   rdy_low = 0;

  motor_drive_stage #(
    .PERIOD(PERIOD), .CNT_W(CNT_W), .DEADTIME(DEADTIME), .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
    .cmd_duty_l(cmd_duty_l), .cmd_duty_r(cmd_duty_r), .cmd_ready(cmd_ready),
    .RMF(RMF), .RMB(RMB), .LMF(LMF), .LMB(LMB),
    .RM_pwm(RM_pwm), .LM_pwm(LM_pwm), .braking(braking)
  );

  always #5 clk = ~clk;

  // Reference PWM counter: cleared in reset, otherwise 0..PERIOD.
  always @(posedge clk) begin
    if (!rst_n)               m_cnt <= 0;
    else if (m_cnt == PERIOD) m_cnt <= 0;
    else                      m_cnt <= m_cnt + 1;
  end

  // Shoot-through watch on every cycle.
  always @(negedge clk) begin
    if ((RMF && RMB) || (LMF && LMB)) fb_viol++;
  end

  function automatic int lines();
    return int'({RMF, RMB, LMF, LMB});
  endfunction

  function automatic int pwms();
    return int'({RM_pwm, LM_pwm});
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_v(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input int obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  // Present a command and hold it until accepted; returns at the first sample after accept.
  task automatic send(input logic [2:0] dir, input int dl, input int dr);
    int guard;
    guard      = 0;
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_duty_l = CNT_W'(dl);
    cmd_duty_r = CNT_W'(dr);
    while (!cmd_ready && guard < 100) begin
      step(1);
      guard++;
    end
    expect_v("send_ready", 1);
    observe(int'(cmd_ready));
    step(1);
    cmd_valid = 1'b0;
  endtask

  // High-time of both PWMs over one full period starting at counter 0.
  task automatic measure(output int hr, output int hl);
    int guard;
    guard = 0;
    hr    = 0;
    hl    = 0;
    while (m_cnt != 0 && guard < 200) begin
      step(1);
      guard++;
    end
    for (int i = 0; i <= PERIOD; i++) begin
      hr += int'(RM_pwm);
      hl += int'(LM_pwm);
      if (!cmd_ready) rdy_low++;
      step(1);
    end
  endtask

  task automatic push_ramp(input string tag, input int n,
                           input int v0, input int v1, input int v2, input int v3);
    int v;
    for (int i = 0; i < n; i++) begin
      v = (i == 0) ? v0 : (i == 1) ? v1 : (i == 2) ? v2 : v3;
      expect_v({tag, "_r"}, v);
      expect_v({tag, "_l"}, v);
    end
  endtask

  task automatic run_ramp(input int n);
    int hr, hl;
    for (int i = 0; i < n; i++) begin
      measure(hr, hl);
      observe(hr);
      observe(hl);
    end
  endtask

  // Count brake cycles from the current sample; flags any live line, PWM or ready during it.
  task automatic brake_len(output int n, output int bad);
    n   = 0;
    bad = 0;
    while (braking && n < 100) begin
      if (lines() != 0 || pwms() != 0 || cmd_ready) bad++;
      n++;
      step(1);
    end
  endtask

  initial begin
    int n, bad;

    // Reset state
    step(3);
    expect_v("rst_lines", 0);
    expect_v("rst_pwm", 0);
    expect_v("rst_braking", 0);
    expect_v("rst_ready", 0);
    observe(lines());
    observe(pwms());
    observe(int'(braking));
    observe(int'(cmd_ready));
    rst_n = 1'b1;
    step(1);
    expect_v("ready_after_rst", 1);
    observe(int'(cmd_ready));

    // 1: forward 80/80 with soft start
    send(3'd0, 80, 80);
    expect_v("t1_lines", 4'b1010);
    expect_v("t1_pwm_low", 0);
    observe(lines());
    observe(pwms());
    step(1);
    rdy_low = 0;
    push_ramp("t1_ramp", 4, 25, 50, 75, 80);
    run_ramp(4);
    expect_v("t1_ready_held", 0);
    observe(rdy_low);

    // 3: same direction, lower duty drops at the next wrap without a brake
    send(3'd0, 30, 30);
    expect_v("t3_braking", 0);
    expect_v("t3_lines", 4'b1010);
    observe(int'(braking));
    observe(lines());
    step(1);
    push_ramp("t3_decrease", 1, 30, 0, 0, 0);
    run_ramp(1);
    send(3'd0, 80, 80);
    step(1);
    push_ramp("t3_reramp", 2, 55, 80, 0, 0);
    run_ramp(2);

    // 2: forward -> back reversal brakes for DEADTIME cycles
    send(3'd4, 60, 60);
    expect_v("t2_braking", 1);
    expect_v("t2_ready_low", 0);
    observe(int'(braking));
    observe(int'(cmd_ready));
    brake_len(n, bad);
    expect_v("t2_brake_len", DEADTIME);
    expect_v("t2_brake_quiet", 0);
    expect_v("t2_lines_back", 4'b0101);
    expect_v("t2_ready_back", 1);
    observe(n);
    observe(bad);
    observe(lines());
    observe(int'(cmd_ready));
    step(1);
    push_ramp("t2_ramp", 3, 25, 50, 60, 0);
    run_ramp(3);

    // 4: back -> fwd, then left (left motor reverses)
    send(3'd0, 40, 40);
    brake_len(n, bad);
    expect_v("t4_fwd_brake_len", DEADTIME);
    observe(n);
    send(3'd1, 50, 50);
    brake_len(n, bad);
    expect_v("t4_left_brake_len", DEADTIME);
    expect_v("t4_left_lines", 4'b1001);
    observe(n);
    observe(lines());
    send(3'd3, 50, 50);
    expect_v("t4_stop_lines", 0);
    expect_v("t4_stop_braking", 0);
    observe(lines());
    observe(int'(braking));
    send(3'd0, 50, 50);
    expect_v("t4_fwd_lines", 4'b1010);
    expect_v("t4_fwd_braking", 0);
    observe(lines());
    observe(int'(braking));
    send(3'd3, 50, 50);
    expect_v("t4_stop2_lines", 0);
    observe(lines());
    send(3'd0, 50, 50);
    expect_v("t4_fwd2_lines", 4'b1010);
    expect_v("t4_fwd2_braking", 0);
    observe(lines());
    observe(int'(braking));

    // 5: undefined code means stop; oversize duty clamps to PERIOD
    send(3'd6, 150, 150);
    expect_v("t5_stop_lines", 0);
    expect_v("t5_stop_braking", 0);
    observe(lines());
    observe(int'(braking));
    step(1);
    push_ramp("t5_stop_pwm", 1, 0, 0, 0, 0);
    run_ramp(1);
    send(3'd0, 150, 150);
    expect_v("t5_fwd_lines", 4'b1010);
    observe(lines());
    step(1);
    push_ramp("t5_clamp_ramp", 4, 25, 50, 75, 99);
    run_ramp(4);

    // 6: reset in the middle of a brake discards the pending direction
    send(3'd4, 60, 60);
    expect_v("t6_braking", 1);
    observe(int'(braking));
    step(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    expect_v("t6_rst_lines", 0);
    expect_v("t6_rst_pwm", 0);
    expect_v("t6_rst_braking", 0);
    expect_v("t6_rst_ready", 0);
    expect_v("t6_rst_counter", 0);
    observe(lines());
    observe(pwms());
    observe(int'(braking));
    observe(int'(cmd_ready));
    observe(int'(dut.cnt_q));
    step(1);
    expect_v("t6_ready_back", 1);
    expect_v("t6_lines_idle", 0);
    observe(int'(cmd_ready));
    observe(lines());
    step(30);
    expect_v("t6_no_pending", 0);
    expect_v("t6_no_brake", 0);
    observe(lines());
    observe(int'(braking));

    expect_v("no_shoot_through", 0);
    observe(fb_viol);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
